// File: rtl/regfile_sequencer_if.sv
// Command handshake plus register-file port bundle between requester, sequencer and register file.
interface regfile_sequencer_if #(
   parameter int DATA_BUS_WIDTH = 8
);
   logic                      cmd_valid;
   logic                      cmd_ready;
   logic [1:0]                cmd_op;
   logic [1:0]                cmd_a;
   logic [1:0]                cmd_b;
   logic [DATA_BUS_WIDTH-1:0] cmd_imm;
   logic                      busy;
   logic                      done;
   logic                      rf_we;
   logic [1:0]                rf_in_sel;
   logic [DATA_BUS_WIDTH-1:0] rf_data_in;
   logic [1:0]                rf_1_sel;
   logic [1:0]                rf_2_sel;
   logic [DATA_BUS_WIDTH-1:0] rf_1_out;
   logic [DATA_BUS_WIDTH-1:0] rf_2_out;

   modport slave (
      input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_imm, rf_1_out, rf_2_out,
      output cmd_ready, busy, done, rf_we, rf_in_sel, rf_data_in, rf_1_sel, rf_2_sel
   );

   modport master (
      output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_imm, rf_1_out, rf_2_out,
      input  cmd_ready, busy, done, rf_we, rf_in_sel, rf_data_in, rf_1_sel, rf_2_sel
   );
endinterface

// File: rtl/regfile_sequencer.sv
// Multi-cycle LOAD/COPY/SWAP/CLEAR_ALL sequencer driving a 4-entry register file
// whose write port captures on the negedge of the cycle the write fields are decoded.
module regfile_sequencer #(
   parameter int DATA_BUS_WIDTH = 8
) (
   input  logic               clock,
   input  logic               reset,
   regfile_sequencer_if.slave bus
);
   localparam logic [1:0] OP_LOAD = 2'd0;
   localparam logic [1:0] OP_COPY = 2'd1;
   localparam logic [1:0] OP_SWAP = 2'd2;
   localparam logic [1:0] OP_CLR  = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE, S_WR_ONE, S_SW_RD, S_SW_WA, S_SW_WB, S_CLR
   } state_t;

   state_t                    r_state;
   logic                      r_done;
   logic [DATA_BUS_WIDTH-1:0] r_temp;
   logic [1:0]                r_cnt;
   logic [1:0]                r_op;
   logic [1:0]                r_a;
   logic [1:0]                r_b;
   logic [DATA_BUS_WIDTH-1:0] r_imm;

   logic                      w_we;
   logic [1:0]                w_in_sel;
   logic [DATA_BUS_WIDTH-1:0] w_data;
   logic [1:0]                w_1_sel;
   logic [1:0]                w_2_sel;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_done  <= 1'b0;
         r_temp  <= '0;
         r_cnt   <= 2'd0;
         r_op    <= 2'd0;
         r_a     <= 2'd0;
         r_b     <= 2'd0;
         r_imm   <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.cmd_valid) begin
                  r_op  <= bus.cmd_op;
                  r_a   <= bus.cmd_a;
                  r_b   <= bus.cmd_b;
                  r_imm <= bus.cmd_imm;
                  case (bus.cmd_op)
                     OP_LOAD, OP_COPY: r_state <= S_WR_ONE;
                     OP_SWAP:          r_state <= S_SW_RD;
                     default: begin
                        r_cnt   <= 2'd0;
                        r_state <= S_CLR;
                     end
                  endcase
               end
            end
            S_WR_ONE: begin
               r_state <= S_IDLE;
               r_done  <= 1'b1;
            end
            S_SW_RD: begin
               r_temp  <= bus.rf_1_out;
               r_state <= S_SW_WA;
            end
            S_SW_WA: r_state <= S_SW_WB;
            S_SW_WB: begin
               r_state <= S_IDLE;
               r_done  <= 1'b1;
            end
            S_CLR: begin
               // Index 3 is the last write; leave instead of wrapping to 0.
               if (r_cnt == 2'd3) begin
                  r_cnt   <= 2'd0;
                  r_state <= S_IDLE;
                  r_done  <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 2'd1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Write fields decode straight from state so the file captures mid-cycle.
   always_comb begin
      w_we     = 1'b0;
      w_in_sel = 2'd0;
      w_data   = '0;
      w_1_sel  = 2'd0;
      w_2_sel  = 2'd0;
      case (r_state)
         S_WR_ONE: begin
            w_we     = 1'b1;
            w_in_sel = r_a;
            if (r_op == OP_COPY) begin
               w_1_sel = r_b;
               w_data  = bus.rf_1_out;
            end else begin
               w_data  = r_imm;
            end
         end
         S_SW_RD: w_1_sel = r_a;
         S_SW_WA: begin
            w_we     = 1'b1;
            w_in_sel = r_a;
            w_2_sel  = r_b;
            w_data   = bus.rf_2_out;
         end
         S_SW_WB: begin
            w_we     = 1'b1;
            w_in_sel = r_b;
            w_data   = r_temp;
         end
         S_CLR: begin
            w_we     = 1'b1;
            w_in_sel = r_cnt;
         end
         default: ;
      endcase
   end

   assign bus.cmd_ready  = (r_state == S_IDLE);
   assign bus.busy       = (r_state != S_IDLE);
   assign bus.done       = r_done;
   assign bus.rf_we      = w_we;
   assign bus.rf_in_sel  = w_in_sel;
   assign bus.rf_data_in = w_data;
   assign bus.rf_1_sel   = w_1_sel;
   assign bus.rf_2_sel   = w_2_sel;
endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer: negedge-capturing register file model, write scoreboard,
// command table plus hand-written back-to-back, busy-ignore and mid-command reset sequences.
module tb_regfile_sequencer;
   localparam int W = 8;

   logic clock = 1'b0;
   logic reset = 1'b1;

   regfile_sequencer_if #(.DATA_BUS_WIDTH(W)) bus ();

   regfile_sequencer #(.DATA_BUS_WIDTH(W)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [1:0]   sel;
      logic [W-1:0] data;
   } wr_t;

   typedef struct {
      logic [1:0]   op;
      logic [1:0]   a;
      logic [1:0]   b;
      logic [W-1:0] imm;
      int           lat;
      logic [W-1:0] r [4];
   } vec_t;

   logic [W-1:0] rf  [4] = '{default: '0};
   logic [W-1:0] mdl [4] = '{default: '0};
   wr_t          sbq [$];
   wr_t          e;
   int           n_chk  = 0;
   int           n_pass = 0;

   assign bus.rf_1_out = rf[bus.rf_1_sel];
   assign bus.rf_2_out = rf[bus.rf_2_sel];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic fail(input string name);
      n_chk++;
      $display("FAIL %s at %0t", name, $time);
   endtask

   // Register file and write scoreboard
   always @(negedge clock) begin
      if (bus.rf_we) begin
         rf[bus.rf_in_sel] <= bus.rf_data_in;
         if (sbq.size() == 0) begin
            fail("unexpected_write");
         end else begin
            e = sbq.pop_front();
            check("wr_sel", {30'd0, bus.rf_in_sel}, {30'd0, e.sel});
            check("wr_data", {24'd0, bus.rf_data_in}, {24'd0, e.data});
         end
      end else begin
         check("idle_data_zero", {24'd0, bus.rf_data_in}, 32'd0);
      end
   end

   task automatic model_push(input logic [1:0] op, a, b, input logic [W-1:0] imm);
      logic [W-1:0] va, vb;
      va = mdl[a];
      vb = mdl[b];
      case (op)
         2'd0: begin sbq.push_back('{a, imm}); mdl[a] = imm; end
         2'd1: begin sbq.push_back('{a, vb});  mdl[a] = vb;  end
         2'd2: begin
            sbq.push_back('{a, vb});
            sbq.push_back('{b, va});
            mdl[a] = vb;
            mdl[b] = va;
         end
         default: for (int i = 0; i < 4; i++) begin
            sbq.push_back('{i[1:0], {W{1'b0}}});
            mdl[i] = '0;
         end
      endcase
   endtask

   task automatic send(input logic [1:0] op, a, b, input logic [W-1:0] imm, output int waits);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_a     = a;
      bus.cmd_b     = b;
      bus.cmd_imm   = imm;
      waits = 0;
      while (!bus.cmd_ready && waits < 50) begin
         @(negedge clock);
         waits++;
      end
      if (!bus.cmd_ready) begin
         fail("accept_timeout");
         bus.cmd_valid = 1'b0;
         return;
      end
      model_push(op, a, b, imm);
      @(posedge clock);
      #1;
      bus.cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input int lat);
      int cnt;
      cnt = 0;
      do begin
         @(negedge clock);
         cnt++;
      end while (!bus.done && cnt < 30);
      check("done_latency", cnt, lat + 1);
   endtask

   function automatic vec_t mk(input logic [1:0] op, a, b, input logic [W-1:0] imm, input int lat,
                               input logic [W-1:0] r0, r1, r2, r3);
      vec_t v;
      v.op = op; v.a = a; v.b = b; v.imm = imm; v.lat = lat;
      v.r[0] = r0; v.r[1] = r1; v.r[2] = r2; v.r[3] = r3;
      return v;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vt [14];
      int   w;
      vt[0]  = mk(2'd0, 2'd2, 2'd0, 8'h5A, 1, 8'h00, 8'h00, 8'h5A, 8'h00);
      vt[1]  = mk(2'd0, 2'd1, 2'd0, 8'h11, 1, 8'h00, 8'h11, 8'h5A, 8'h00);
      vt[2]  = mk(2'd0, 2'd3, 2'd0, 8'hC3, 1, 8'h00, 8'h11, 8'h5A, 8'hC3);
      vt[3]  = mk(2'd2, 2'd1, 2'd3, 8'h00, 3, 8'h00, 8'hC3, 8'h5A, 8'h11);
      vt[4]  = mk(2'd0, 2'd2, 2'd0, 8'h7E, 1, 8'h00, 8'hC3, 8'h7E, 8'h11);
      vt[5]  = mk(2'd1, 2'd0, 2'd2, 8'h00, 1, 8'h7E, 8'hC3, 8'h7E, 8'h11);
      vt[6]  = mk(2'd1, 2'd1, 2'd1, 8'h00, 1, 8'h7E, 8'hC3, 8'h7E, 8'h11);
      vt[7]  = mk(2'd2, 2'd2, 2'd2, 8'h00, 3, 8'h7E, 8'hC3, 8'h7E, 8'h11);
      vt[8]  = mk(2'd0, 2'd0, 2'd0, 8'hFF, 1, 8'hFF, 8'hC3, 8'h7E, 8'h11);
      vt[9]  = mk(2'd0, 2'd1, 2'd0, 8'hFF, 1, 8'hFF, 8'hFF, 8'h7E, 8'h11);
      vt[10] = mk(2'd0, 2'd2, 2'd0, 8'hFF, 1, 8'hFF, 8'hFF, 8'hFF, 8'h11);
      vt[11] = mk(2'd0, 2'd3, 2'd0, 8'hFF, 1, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
      vt[12] = mk(2'd3, 2'd0, 2'd0, 8'h00, 4, 8'h00, 8'h00, 8'h00, 8'h00);
      vt[13] = mk(2'd0, 2'd3, 2'd0, 8'hA5, 1, 8'h00, 8'h00, 8'h00, 8'hA5);

      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 2'd0;
      bus.cmd_a     = 2'd0;
      bus.cmd_b     = 2'd0;
      bus.cmd_imm   = '0;

      #2 reset = 1'b0;
      #1;
      check("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
      check("rst_done", {31'd0, bus.done}, 32'd0);
      check("rst_rf_we", {31'd0, bus.rf_we}, 32'd0);
      check("rst_data", {24'd0, bus.rf_data_in}, 32'd0);
      check("rst_sel1", {30'd0, bus.rf_1_sel}, 32'd0);
      check("rst_sel2", {30'd0, bus.rf_2_sel}, 32'd0);
      repeat (2) @(negedge clock);
      #1 reset = 1'b1;
      @(negedge clock);

      // Table: each command issued in the done cycle of the previous one
      for (int i = 0; i < 14; i++) begin
         send(vt[i].op, vt[i].a, vt[i].b, vt[i].imm, w);
         check($sformatf("v%0d_accept_wait", i), w, 0);
         wait_done(vt[i].lat);
         for (int r = 0; r < 4; r++)
            check($sformatf("v%0d_R%0d", i, r), {24'd0, rf[r]}, {24'd0, vt[i].r[r]});
      end

      // New command raised while CLEAR_ALL runs waits for the done cycle
      send(2'd3, 2'd0, 2'd0, 8'h00, w);
      check("clr_ready_low", {31'd0, bus.cmd_ready}, 32'd0);
      fork
         wait_done(4);
         begin
            int w2;
            send(2'd0, 2'd1, 2'd0, 8'h33, w2);
            check("busy_ignored_wait", w2, 5);
         end
      join
      wait_done(1);
      check("after_clr_R1", {24'd0, rf[1]}, 32'h33);
      check("after_clr_R3", {24'd0, rf[3]}, 32'h00);

      // Reset pulse inside SW_WA aborts the swap after the A write
      send(2'd0, 2'd0, 2'd0, 8'h01, w);
      wait_done(1);
      send(2'd0, 2'd1, 2'd0, 8'h02, w);
      wait_done(1);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 2'd2;
      bus.cmd_a     = 2'd0;
      bus.cmd_b     = 2'd1;
      @(posedge clock);
      #1 bus.cmd_valid = 1'b0;
      sbq.push_back('{2'd0, 8'h02});
      @(posedge clock);
      @(negedge clock);
      #1 reset = 1'b0;
      #1;
      check("abort_rf_we", {31'd0, bus.rf_we}, 32'd0);
      check("abort_busy", {31'd0, bus.busy}, 32'd0);
      check("abort_ready", {31'd0, bus.cmd_ready}, 32'd1);
      check("abort_data", {24'd0, bus.rf_data_in}, 32'd0);
      reset = 1'b1;
      repeat (4) begin
         @(negedge clock);
         check("abort_no_done", {31'd0, bus.done}, 32'd0);
      end
      check("abort_R0", {24'd0, rf[0]}, 32'h02);
      check("abort_R1", {24'd0, rf[1]}, 32'h02);
      check("sb_drained", sbq.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
